// File: rtl/mem_resp_stage_pkg.sv
// Shared types for the memory-response stage: load-op codes, writeback-source
// codes and the stage occupancy state.
package mem_resp_stage_pkg;

  // Load types as encoded by the decoder.
  typedef enum logic [2:0] {
    LdW  = 3'd0,
    LdB  = 3'd1,
    LdBu = 3'd2,
    LdH  = 3'd3,
    LdHu = 3'd4,
    LdD  = 3'd5
  } ld_op_e;

  // Writeback source select.
  typedef enum logic [1:0] {
    ResAlu  = 2'd0,
    ResLoad = 2'd1,
    ResMul  = 2'd2,
    ResDiv  = 2'd3
  } res_sel_e;

  // Stage occupancy: empty, waiting on a memory response, or ready to hand off.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } state_e;

  // Number of address bits that select a byte within one datapath word.
  function automatic int unsigned off_width(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_resp_stage_load_align.sv
// Byte-offset alignment and sign/zero extension of raw load data.
module mem_resp_stage_load_align
  import mem_resp_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = 2
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [OFF_W-1:0]  off,
  input  ld_op_e            ld_op,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  // Shift the addressed bytes down to bit 0, then extend to the full width.
  always_comb begin
    shifted = raw >> {off, 3'b000};
    data    = shifted;
    case (ld_op)
      LdB:     data = DATA_W'($signed(shifted[7:0]));
      LdBu:    data = DATA_W'(shifted[7:0]);
      LdH:     data = DATA_W'($signed(shifted[15:0]));
      LdHu:    data = DATA_W'(shifted[15:0]);
      LdW:     data = DATA_W'($signed(shifted[31:0]));
      LdD:     data = shifted;
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM pipeline stage that waits on a variable-latency data-memory response,
// aligns loads, selects the writeback source and drops responses owed to
// instructions killed by a flush.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              resetn,
  // EX side
  input  logic              ex_to_mem_valid,
  output logic              mem_allowin,
  input  logic              in_rf_we,
  input  logic [4:0]        in_rf_waddr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [1:0]        in_res_sel,
  input  logic [2:0]        in_ld_op,
  input  logic              in_req_issued,
  input  logic [DATA_W-1:0] in_div_result,
  input  logic [DATA_W-1:0] mul_result,
  // Data memory response
  input  logic              data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  // WB side
  input  logic              flush,
  input  logic              wb_allowin,
  output logic              mem_to_wb_valid,
  output logic              out_rf_we,
  output logic [4:0]        out_rf_waddr,
  output logic [DATA_W-1:0] out_rf_wdata,
  output logic [PC_W-1:0]   out_pc,
  // Forwarding / hazard
  output logic              fwd_we,
  output logic [4:0]        fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              fwd_pending,
  output logic              discard_busy
);

  localparam int unsigned OffW = off_width(DATA_W);
  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTST);

  state_e            state_q;
  logic              rf_we_q;
  logic [4:0]        rf_waddr_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] div_result_q;
  logic [1:0]        res_sel_q;
  logic [2:0]        ld_op_q;
  logic              req_issued_q;
  logic [DATA_W-1:0] rdata_buf_q;
  logic [CntW-1:0]   discard_cnt_q;

  logic              mem_valid;
  logic              need_resp;
  logic              have_data;
  logic              data_acc;
  logic              mem_ready_go;
  logic              leaving;
  logic              load_payload;
  logic              disc_inc;
  logic              disc_dec;
  logic [DATA_W-1:0] live_aligned;
  logic [DATA_W-1:0] wdata;

  // READY with a request outstanding means the response is sitting in rdata_buf.
  assign mem_valid    = (state_q != StIdle);
  assign need_resp    = req_issued_q;
  assign have_data    = (state_q == StReady) & req_issued_q;
  assign data_acc     = data_ok & (discard_cnt_q == '0);
  assign mem_ready_go = ~need_resp | have_data | data_acc;
  assign leaving      = mem_to_wb_valid & wb_allowin;
  assign load_payload = ex_to_mem_valid & mem_allowin & ~flush;

  assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & mem_ready_go & ~flush;

  mem_resp_stage_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OffW)
  ) u_load_align (
    .raw   (data_rdata),
    .off   (alu_result_q[OffW-1:0]),
    .ld_op (ld_op_e'(ld_op_q)),
    .data  (live_aligned)
  );

  // Stage FSM: occupancy, payload capture and response buffering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      pc_q         <= '0;
      alu_result_q <= '0;
      div_result_q <= '0;
      res_sel_q    <= '0;
      ld_op_q      <= '0;
      req_issued_q <= 1'b0;
      rdata_buf_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
    end else if (load_payload) begin
      state_q      <= in_req_issued ? StWait : StReady;
      rf_we_q      <= in_rf_we;
      rf_waddr_q   <= in_rf_waddr;
      pc_q         <= in_pc;
      alu_result_q <= in_alu_result;
      div_result_q <= in_div_result;
      res_sel_q    <= in_res_sel;
      ld_op_q      <= in_ld_op;
      req_issued_q <= in_req_issued;
    end else if (leaving) begin
      state_q <= StIdle;
    end else if ((state_q == StWait) && data_acc) begin
      // WB is stalling: keep the response since it will not be re-sent.
      state_q     <= StReady;
      rdata_buf_q <= live_aligned;
    end
  end

  // A killed load still owes a response unless it arrives in the flush cycle.
  assign disc_inc = flush & (state_q == StWait) & ~data_acc;
  assign disc_dec = data_ok & (discard_cnt_q != '0);

  // Count of in-flight responses that belong to flushed loads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard_cnt_q <= '0;
    end else if (disc_inc && !disc_dec) begin
      if (discard_cnt_q != CntMax) begin
        discard_cnt_q <= discard_cnt_q + 1'b1;
      end
    end else if (disc_dec && !disc_inc) begin
      discard_cnt_q <= discard_cnt_q - 1'b1;
    end
  end

  // Writeback source select.
  always_comb begin
    wdata = alu_result_q;
    unique case (res_sel_e'(res_sel_q))
      ResAlu:  wdata = alu_result_q;
      ResLoad: wdata = have_data ? rdata_buf_q : live_aligned;
      ResMul:  wdata = mul_result;
      ResDiv:  wdata = div_result_q;
    endcase
  end

  assign out_rf_we    = rf_we_q;
  assign out_rf_waddr = rf_waddr_q;
  assign out_rf_wdata = wdata;
  assign out_pc       = pc_q;

  assign fwd_we       = mem_valid & rf_we_q;
  assign fwd_waddr    = rf_waddr_q;
  assign fwd_wdata    = wdata;
  assign fwd_pending  = (state_q == StWait) & ~data_acc;
  assign discard_busy = (discard_cnt_q != '0);

`ifndef SYNTHESIS
  // EX must never leave more responses outstanding than the counter can track.
  discard_ceiling_a : assert property (
    @(posedge clk) disable iff (!resetn) discard_cnt_q != CntMax
  );
`endif

endmodule

// File: tb/tb_mem_resp_stage.sv
module tb_mem_resp_stage;
  import mem_resp_stage_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ex_to_mem_valid = 1'b0;
  logic        mem_allowin;
  logic        in_rf_we = 1'b0;
  logic [4:0]  in_rf_waddr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_alu_result = '0;
  logic [1:0]  in_res_sel = '0;
  logic [2:0]  in_ld_op = '0;
  logic        in_req_issued = 1'b0;
  logic [31:0] in_div_result = '0;
  logic [31:0] mul_result = '0;
  logic        data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        flush = 1'b0;
  logic        wb_allowin = 1'b1;
  logic        mem_to_wb_valid;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic [31:0] out_rf_wdata;
  logic [31:0] out_pc;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        fwd_pending;
  logic        discard_busy;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mem_resp_stage #(
    .DATA_W    (32),
    .PC_W      (32),
    .MAX_OUTST (2)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_to_mem_valid (ex_to_mem_valid),
    .mem_allowin     (mem_allowin),
    .in_rf_we        (in_rf_we),
    .in_rf_waddr     (in_rf_waddr),
    .in_pc           (in_pc),
    .in_alu_result   (in_alu_result),
    .in_res_sel      (in_res_sel),
    .in_ld_op        (in_ld_op),
    .in_req_issued   (in_req_issued),
    .in_div_result   (in_div_result),
    .mul_result      (mul_result),
    .data_ok         (data_ok),
    .data_rdata      (data_rdata),
    .flush           (flush),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .out_rf_we       (out_rf_we),
    .out_rf_waddr    (out_rf_waddr),
    .out_rf_wdata    (out_rf_wdata),
    .out_pc          (out_pc),
    .fwd_we          (fwd_we),
    .fwd_waddr       (fwd_waddr),
    .fwd_wdata       (fwd_wdata),
    .fwd_pending     (fwd_pending),
    .discard_busy    (discard_busy)
  );

  // Present one instruction for a single accept edge; returns at posedge+1.
  task automatic send(input logic [4:0] waddr, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [1:0] sel, input logic [2:0] ld, input logic req,
                      input logic [31:0] div);
    ex_to_mem_valid = 1'b1;
    in_rf_we        = 1'b1;
    in_rf_waddr     = waddr;
    in_pc           = pc;
    in_alu_result   = alu;
    in_res_sel      = sel;
    in_ld_op        = ld;
    in_req_issued   = req;
    in_div_result   = div;
    @(posedge clk);
    #1;
    ex_to_mem_valid = 1'b0;
    in_req_issued   = 1'b0;
    in_alu_result   = 32'hA5A5_A5A5;
    in_div_result   = 32'h0;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    if (exp_q.size() == 0) begin
      e  = '0;
      ok = 1'b0;
    end else begin
      e  = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    #12;
    tests_run++;
    if (mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_handshake: got valid=%b allowin=%b want valid=0 allowin=1",
               mem_to_wb_valid, mem_allowin);
    end
    tests_run++;
    if ({out_rf_we, out_rf_waddr, out_rf_wdata, out_pc} !== '0 || fwd_we !== 1'b0 ||
        fwd_pending !== 1'b0 || discard_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got we=%b waddr=%0d wdata=%h pc=%h fwd_we=%b pend=%b busy=%b want all 0",
               out_rf_we, out_rf_waddr, out_rf_wdata, out_pc, fwd_we, fwd_pending, discard_busy);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu;
    exp_t e;
    bit   ok;
    exp_q.push_back('{waddr: 5'd3, wdata: 32'h0000_1234, pc: 32'h0000_0100});
    send(5'd3, 32'h100, 32'h1234, ResAlu, LdW, 1'b0, 32'h0);
    @(negedge clk);
    tests_run++;
    if (mem_to_wb_valid !== 1'b1 || fwd_we !== 1'b1 || fwd_waddr !== 5'd3 ||
        fwd_wdata !== 32'h1234) begin
      tests_failed++;
      $display("FAIL alu_valid_fwd: got valid=%b fwd_we=%b fwd_waddr=%0d fwd_wdata=%h want 1 1 3 00001234",
               mem_to_wb_valid, fwd_we, fwd_waddr, fwd_wdata);
    end
    pop_exp(e, ok);
    tests_run++;
    if (!ok || out_rf_waddr !== e.waddr || out_rf_wdata !== e.wdata || out_pc !== e.pc) begin
      tests_failed++;
      $display("FAIL alu_wb: got waddr=%0d wdata=%h pc=%h want waddr=%0d wdata=%h pc=%h",
               out_rf_waddr, out_rf_wdata, out_pc, e.waddr, e.wdata, e.pc);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++;
    if (mem_to_wb_valid !== 1'b0 || fwd_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL alu_drain: got valid=%b fwd_we=%b want 0 0", mem_to_wb_valid, fwd_we);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul_div;
    exp_t e;
    bit   ok;
    exp_q.push_back('{waddr: 5'd4, wdata: 32'hCAFE_0001, pc: 32'h0000_0104});
    send(5'd4, 32'h104, 32'h0, ResMul, LdW, 1'b0, 32'h0);
    mul_result = 32'hCAFE_0001;
    @(negedge clk);
    pop_exp(e, ok);
    tests_run++;
    if (mem_to_wb_valid !== 1'b1 || !ok || out_rf_waddr !== e.waddr ||
        out_rf_wdata !== e.wdata || out_pc !== e.pc) begin
      tests_failed++;
      $display("FAIL mul_wb: got valid=%b waddr=%0d wdata=%h pc=%h want valid=1 waddr=%0d wdata=%h pc=%h",
               mem_to_wb_valid, out_rf_waddr, out_rf_wdata, out_pc, e.waddr, e.wdata, e.pc);
    end
    @(posedge clk);
    #1;
    mul_result = 32'h0;
    exp_q.push_back('{waddr: 5'd5, wdata: 32'h0BAD_0002, pc: 32'h0000_0108});
    send(5'd5, 32'h108, 32'h0, ResDiv, LdW, 1'b0, 32'h0BAD_0002);
    @(negedge clk);
    pop_exp(e, ok);
    tests_run++;
    if (mem_to_wb_valid !== 1'b1 || !ok || out_rf_waddr !== e.waddr ||
        out_rf_wdata !== e.wdata || out_pc !== e.pc) begin
      tests_failed++;
      $display("FAIL div_wb: got valid=%b waddr=%0d wdata=%h pc=%h want valid=1 waddr=%0d wdata=%h pc=%h",
               mem_to_wb_valid, out_rf_waddr, out_rf_wdata, out_pc, e.waddr, e.wdata, e.pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit   ok;
    exp_q.push_back('{waddr: 5'd6, wdata: 32'h1111_0006, pc: 32'h0000_0200});
    exp_q.push_back('{waddr: 5'd7, wdata: 32'h2222_0007, pc: 32'h0000_0204});
    ex_to_mem_valid = 1'b1;
    in_rf_we = 1'b1; in_rf_waddr = 5'd6; in_pc = 32'h200; in_alu_result = 32'h1111_0006;
    in_res_sel = ResAlu; in_req_issued = 1'b0;
    @(posedge clk);
    #1;
    in_rf_waddr = 5'd7; in_pc = 32'h204; in_alu_result = 32'h2222_0007;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      pop_exp(e, ok);
      tests_run++;
      if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b1 || !ok ||
          out_rf_waddr !== e.waddr || out_rf_wdata !== e.wdata || out_pc !== e.pc) begin
        tests_failed++;
        $display("FAIL b2b_%0d: got valid=%b allowin=%b waddr=%0d wdata=%h pc=%h want 1 1 %0d %h %h",
                 k, mem_to_wb_valid, mem_allowin, out_rf_waddr, out_rf_wdata, out_pc,
                 e.waddr, e.wdata, e.pc);
      end
      @(posedge clk);
      #1;
      ex_to_mem_valid = 1'b0;
    end
  endtask

  task automatic test_load_align;
    logic [31:0] addrs[5] = '{32'h1002, 32'h1002, 32'h1000, 32'h1002, 32'h1000};
    logic [2:0]  ops[5]   = '{LdB, LdBu, LdHu, LdH, LdW};
    logic [31:0] raws[5]  = '{32'h0080_0000, 32'h0080_0000, 32'h1234_F00D, 32'h8001_0000,
                              32'h8765_4321};
    logic [31:0] wants[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_F00D, 32'hFFFF_8001,
                              32'h8765_4321};
    exp_t e;
    bit   ok;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{waddr: 5'(8 + i), wdata: wants[i], pc: 32'h300 + 32'(i)});
      send(5'(8 + i), 32'h300 + 32'(i), addrs[i], ResLoad, ops[i], 1'b1, 32'h0);
      data_ok    = 1'b1;
      data_rdata = raws[i];
      @(negedge clk);
      pop_exp(e, ok);
      tests_run++;
      if (mem_to_wb_valid !== 1'b1 || fwd_pending !== 1'b0 || !ok ||
          out_rf_waddr !== e.waddr || out_rf_wdata !== e.wdata || out_pc !== e.pc) begin
        tests_failed++;
        $display("FAIL load_align_%0d: got valid=%b pend=%b waddr=%0d wdata=%h pc=%h want 1 0 %0d %h %h",
                 i, mem_to_wb_valid, fwd_pending, out_rf_waddr, out_rf_wdata, out_pc,
                 e.waddr, e.wdata, e.pc);
      end
      @(posedge clk);
      #1;
      data_ok    = 1'b0;
      data_rdata = 32'h0;
    end
  endtask

  task automatic test_delayed_load;
    exp_t e;
    bit   ok;
    exp_q.push_back('{waddr: 5'd14, wdata: 32'hFFFF_8001, pc: 32'h0000_0400});
    send(5'd14, 32'h400, 32'h2002, ResLoad, LdH, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (fwd_pending !== 1'b1 || mem_to_wb_valid !== 1'b0 || mem_allowin !== 1'b0) begin
        tests_failed++;
        $display("FAIL delay_wait_%0d: got pend=%b valid=%b allowin=%b want 1 0 0",
                 k, fwd_pending, mem_to_wb_valid, mem_allowin);
      end
      @(posedge clk);
      #1;
    end
    data_ok    = 1'b1;
    data_rdata = 32'h8001_0000;
    @(negedge clk);
    pop_exp(e, ok);
    tests_run++;
    if (mem_to_wb_valid !== 1'b1 || fwd_pending !== 1'b0 || !ok ||
        out_rf_waddr !== e.waddr || out_rf_wdata !== e.wdata || out_pc !== e.pc) begin
      tests_failed++;
      $display("FAIL delay_result: got valid=%b pend=%b waddr=%0d wdata=%h pc=%h want 1 0 %0d %h %h",
               mem_to_wb_valid, fwd_pending, out_rf_waddr, out_rf_wdata, out_pc,
               e.waddr, e.wdata, e.pc);
    end
    @(posedge clk);
    #1;
    data_ok    = 1'b0;
    data_rdata = 32'h0;
  endtask

  task automatic test_wb_stall;
    exp_t e;
    bit   ok;
    exp_q.push_back('{waddr: 5'd15, wdata: 32'hDEAD_BEEF, pc: 32'h0000_0500});
    wb_allowin = 1'b0;
    send(5'd15, 32'h500, 32'h3000, ResLoad, LdW, 1'b1, 32'h0);
    data_ok    = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tests_run++;
    if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_first: got valid=%b allowin=%b want 1 0", mem_to_wb_valid, mem_allowin);
    end
    @(posedge clk);
    #1;
    data_ok    = 1'b0;
    data_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    tests_run++;
    if (mem_to_wb_valid !== 1'b1 || fwd_pending !== 1'b0 || out_rf_wdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL stall_buffered: got valid=%b pend=%b wdata=%h want 1 0 deadbeef",
               mem_to_wb_valid, fwd_pending, out_rf_wdata);
    end
    @(posedge clk);
    #1;
    wb_allowin = 1'b1;
    @(negedge clk);
    pop_exp(e, ok);
    tests_run++;
    if (mem_to_wb_valid !== 1'b1 || mem_allowin !== 1'b1 || !ok ||
        out_rf_waddr !== e.waddr || out_rf_wdata !== e.wdata || out_pc !== e.pc) begin
      tests_failed++;
      $display("FAIL stall_release: got valid=%b allowin=%b waddr=%0d wdata=%h pc=%h want 1 1 %0d %h %h",
               mem_to_wb_valid, mem_allowin, out_rf_waddr, out_rf_wdata, out_pc,
               e.waddr, e.wdata, e.pc);
    end
    @(posedge clk);
    #1;
    data_rdata = 32'h0;
  endtask

  task automatic test_flush_discard;
    exp_t e;
    bit   ok;
    send(5'd16, 32'h600, 32'h4000, ResLoad, LdW, 1'b1, 32'h0);
    @(negedge clk);
    tests_run++;
    if (fwd_pending !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_prewait: got pend=%b want 1", fwd_pending);
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mem_to_wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_cycle_valid: got %b want 0", mem_to_wb_valid);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if (discard_busy !== 1'b1 || fwd_we !== 1'b0 || mem_to_wb_valid !== 1'b0 ||
        fwd_pending !== 1'b0 || mem_allowin !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_after: got busy=%b fwd_we=%b valid=%b pend=%b allowin=%b want 1 0 0 0 1",
               discard_busy, fwd_we, mem_to_wb_valid, fwd_pending, mem_allowin);
    end
    @(posedge clk);
    #1;
    data_ok    = 1'b1;
    data_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    data_ok    = 1'b0;
    data_rdata = 32'h0;
    @(negedge clk);
    tests_run++;
    if (discard_busy !== 1'b0 || mem_to_wb_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL discard_drop: got busy=%b valid=%b want 0 0", discard_busy, mem_to_wb_valid);
    end
    @(posedge clk);
    #1;
    exp_q.push_back('{waddr: 5'd17, wdata: 32'h55AA_55AA, pc: 32'h0000_0604});
    send(5'd17, 32'h604, 32'h4004, ResLoad, LdW, 1'b1, 32'h0);
    data_ok    = 1'b1;
    data_rdata = 32'h55AA_55AA;
    @(negedge clk);
    pop_exp(e, ok);
    tests_run++;
    if (mem_to_wb_valid !== 1'b1 || !ok || out_rf_waddr !== e.waddr ||
        out_rf_wdata !== e.wdata || out_pc !== e.pc) begin
      tests_failed++;
      $display("FAIL post_flush_load: got valid=%b waddr=%0d wdata=%h pc=%h want 1 %0d %h %h",
               mem_to_wb_valid, out_rf_waddr, out_rf_wdata, out_pc, e.waddr, e.wdata, e.pc);
    end
    @(posedge clk);
    #1;
    data_ok    = 1'b0;
    data_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_wait;
    // A flushed load leaves a pending discard; reset must clear it at once.
    send(5'd18, 32'h700, 32'h5000, ResLoad, LdW, 1'b1, 32'h0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if (discard_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_busy: got %b want 1", discard_busy);
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (discard_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async_busy: got %b want 0", discard_busy);
    end
    #3;
    resetn = 1'b1;
    send(5'd19, 32'h704, 32'h5004, ResLoad, LdW, 1'b1, 32'h0);
    @(negedge clk);
    tests_run++;
    if (fwd_pending !== 1'b1 || fwd_we !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_wait_state: got pend=%b fwd_we=%b want 1 1", fwd_pending, fwd_we);
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (mem_to_wb_valid !== 1'b0 || fwd_pending !== 1'b0 || fwd_we !== 1'b0 ||
        mem_allowin !== 1'b1 || discard_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async_ctrl: got valid=%b pend=%b fwd_we=%b allowin=%b busy=%b want 0 0 0 1 0",
               mem_to_wb_valid, fwd_pending, fwd_we, mem_allowin, discard_busy);
    end
    tests_run++;
    if ({out_rf_we, out_rf_waddr, out_rf_wdata, out_pc} !== '0) begin
      tests_failed++;
      $display("FAIL rst_async_payload: got we=%b waddr=%0d wdata=%h pc=%h want all 0",
               out_rf_we, out_rf_waddr, out_rf_wdata, out_pc);
    end
    #3;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_mul_div();
    test_back_to_back();
    test_load_align();
    test_delayed_load();
    test_wb_stall();
    test_flush_discard();
    test_reset_mid_wait();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_resp_stage.md
# mem_resp_stage

Parametrised memory-response pipeline stage for the five-stage core. It replaces the fixed-latency MEM stage with one that waits on a variable-latency data-memory response, aligns and sign-extends sub-word loads by byte offset, and selects the writeback source. It also discards responses owed to instructions killed by a pipeline flush. It sits between the EX stage, which issues data requests, and the WB stage, and drives the MEM-stage forwarding bus.

## Interface
- DATA_W, 32, datapath width; legal values are 32 and 64.
- PC_W, 32, program-counter width.
- MAX_OUTST, 2, maximum responses that can still be owed to flushed loads; sets the discard-counter width to $clog2(MAX_OUTST+1).
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ex_to_mem_valid  in  1  EX is presenting an instruction.
- mem_allowin  out  1  MEM accepts the EX instruction this cycle.
- in_rf_we / in_rf_waddr / in_pc  in  1/5/PC_W  destination write enable, destination register, PC.
- in_alu_result  in  DATA_W  ALU result; for memory ops this is the address, and its low bits are the byte offset.
- in_res_sel  in  2  writeback source: 0 ALU, 1 load, 2 mul, 3 div.
- in_ld_op  in  3  load type: 0 W, 1 B, 2 BU, 3 H, 4 HU, 5 D (D is legal only when DATA_W=64).
- in_req_issued  in  1  EX had its data request accepted; MEM must therefore collect one response.
- in_div_result  in  DATA_W  divider result, latched with the payload.
- mul_result  in  DATA_W  combinational output of the final multiplier stage, valid while MEM holds a mul.
- data_ok / data_rdata  in  1/DATA_W  memory response strobe and its data.
- flush  in  1  kill the instruction held in MEM (driven by WB on an exception or ertn).
- wb_allowin  in  1  WB accepts this cycle.
- mem_to_wb_valid  out  1  output is valid.
- out_rf_we / out_rf_waddr / out_rf_wdata / out_pc  out  1/5/DATA_W/PC_W  payload sent to WB.
- fwd_we / fwd_waddr / fwd_wdata  out  1/5/DATA_W  forwarding bus; fwd_we = mem_valid & out_rf_we.
- fwd_pending  out  1  MEM holds a load whose data is not yet available; ID must stall instead of forwarding.
- discard_busy  out  1  the discard count is nonzero; EX must not issue a new request while this is high.

## Operation
- Internal state:
  - mem_valid: stage occupied.
  - Payload register.
  - have_data and rdata_buf[DATA_W]: the response has arrived and its aligned result is buffered.
  - discard_cnt: number of in-flight responses to drop.
- need_resp: the payload has in_req_issued set.
- Response acceptance:
  - An accepted data_ok is data_ok with discard_cnt==0.
  - When discard_cnt>0, data_ok decrements the count and is not used.
- Ready condition: mem_ready_go = ~need_resp | have_data | accepted data_ok.
- Handshake:
  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
  - mem_to_wb_valid = mem_valid & mem_ready_go & ~flush.
- Payload load: the payload loads on ex_to_mem_valid & mem_allowin & ~flush. That same edge clears have_data.
- Response buffering: an accepted data_ok while the stage is stalled (mem_valid, need_resp, ~have_data, not leaving) sets have_data and writes the aligned value to rdata_buf.
- Alignment:
  - off = in_alu_result[$clog2(DATA_W/8)-1:0].
  - The raw word is shifted right by off*8.
  - B and H are sign-extended; BU and HU are zero-extended.
  - W is sign-extended to DATA_W; D passes through unchanged.
- Writeback data: out_rf_wdata comes from the source selected by in_res_sel. For loads it is rdata_buf when have_data is set, otherwise the aligned data_rdata.
- Flush:
  - mem_valid clears on the next edge. Flush has priority over an incoming instruction.
  - If the flushed instruction has need_resp & ~have_data and no accepted data_ok arrives in the flush cycle, discard_cnt increments.
  - If an increment and a discard-decrement coincide, the count is unchanged.
  - discard_cnt saturates at MAX_OUTST; reaching that ceiling is a protocol violation and is flagged by an assertion.
- States (encoded): IDLE (~mem_valid), WAIT (valid, need_resp, no data), READY (valid, data available or none needed). Transitions:
  - IDLE→WAIT/READY on accept.
  - WAIT→READY on accepted data_ok.
  - READY→IDLE or a new state on handoff.
  - Any state→IDLE on flush.

## Timing
- Reset values, applied asynchronously and held until the first edge after release: mem_valid=0, have_data=0, discard_cnt=0, payload=0. Consequently every output is 0 and mem_allowin=1.
- The earliest data_ok comes one cycle after the EX request was accepted, which is the first MEM cycle. A load with an immediate response passes through in one cycle, with zero added latency.
- A non-load passes through in one cycle whenever wb_allowin is high.
- A response arriving while WB stalls is held in rdata_buf. data_ok is never required to be re-sent.
- fwd_pending = mem_valid & need_resp & ~have_data & ~(accepted data_ok).
- Back-to-back instructions are supported: a new payload is accepted on the same edge the old one is handed off.

## Structure
- Shared package: the load-op codes (LD_W…LD_D), the res_sel codes, and the state enum.
- Sub-module load_align: combinational shift and extend, parametrised by DATA_W. It is used for both the live path and the buffered path.

## Test plan
- ALU op, in_res_sel=0, in_alu_result=0x1234, wb_allowin=1 -> next cycle mem_to_wb_valid=1, out_rf_wdata=0x1234.
- ld.b at offset 2, data_rdata=0x00_80_00_00 arriving in the first MEM cycle -> out_rf_wdata=0xFFFFFF80. The same case as ld.bu -> 0x00000080.
- ld.h with data_ok delayed 3 cycles -> fwd_pending=1 for 3 cycles, mem_to_wb_valid=0 during the wait, then the aligned result on the 4th cycle.
- Response arrives while wb_allowin=0 for 2 cycles, data_rdata=0xDEADBEEF, ld.w -> the value is buffered; when wb_allowin rises, out_rf_wdata=0xDEADBEEF is delivered even though data_ok is now low.
- Flush during WAIT -> mem_valid=0 next cycle and discard_cnt=1. The following data_ok is dropped (discard_cnt=0), and a new ld.w then receives its own response 0x55AA55AA.
- resetn asserted mid-WAIT -> all outputs 0 immediately (asynchronously) and discard_cnt=0.
